// File: rtl/line_mem_pkg.sv
// Shared types and constants for the line memory model.
package line_mem_pkg;

  localparam int unsigned LINE_W      = 256;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned OFFSET_BITS = 5;
  localparam int unsigned IDX_W       = ADDR_W - OFFSET_BITS;
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned STAT_W      = 32;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_ACK  = 2'd2;

  // Request captured at acceptance and held for the whole transaction.
  typedef struct packed {
    logic              write;
    logic [IDX_W-1:0]  idx;
    logic [LINE_W-1:0] data;
  } req_t;

  // Line index of a byte address (drops the in-line byte offset).
  function automatic logic [IDX_W-1:0] line_index(input logic [ADDR_W-1:0] addr);
    return IDX_W'(addr >> OFFSET_BITS);
  endfunction

endpackage

// File: rtl/line_memory_if.sv
// Request/response bundle between the cache controller and the line memory.
interface line_memory_if;

  logic                                enable_i;
  logic                                write_i;
  logic [line_mem_pkg::ADDR_W-1:0]     addr_i;
  logic [line_mem_pkg::LINE_W-1:0]     data_i;
  logic                                ack_o;
  logic [line_mem_pkg::LINE_W-1:0]     data_o;
  logic                                err_o;
  logic                                busy_o;
  logic [line_mem_pkg::STAT_W-1:0]     rd_count_o;
  logic [line_mem_pkg::STAT_W-1:0]     wr_count_o;

  modport slave (
    input  enable_i, write_i, addr_i, data_i,
    output ack_o, data_o, err_o, busy_o, rd_count_o, wr_count_o
  );

  modport master (
    output enable_i, write_i, addr_i, data_i,
    input  ack_o, data_o, err_o, busy_o, rd_count_o, wr_count_o
  );

endinterface

// File: rtl/line_mem_array.sv
// Single-port line storage: synchronous write, asynchronous read, no reset.
module line_mem_array
  import line_mem_pkg::*;
#(
  parameter  int unsigned DEPTH = 512,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic [LINE_W-1:0] rdata_c
);

  logic [LINE_W-1:0] mem_q [DEPTH];

  // Line write; contents intentionally survive reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_c = mem_q[addr_i];

endmodule

// File: rtl/line_memory.sv
// Fixed-latency main-memory model serving one cache line per request.
// LATENCY must lie in 1..255.
module line_memory
  import line_mem_pkg::*;
#(
  parameter int unsigned LATENCY = 10,
  parameter int unsigned DEPTH   = 512
) (
  input  logic          clk_i,
  input  logic          rst_i,
  line_memory_if.slave  bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  req_t               req_q, req_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic [LINE_W-1:0]  data_q, data_d;
  logic [STAT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [STAT_W-1:0]  wr_cnt_q, wr_cnt_d;

  logic               we_c;
  logic               in_range_d_c;
  logic               in_range_q_c;
  logic [LINE_W-1:0]  rdata_c;

  // Storage; addressed by the request that is (or is about to be) active.
  line_mem_array #(.DEPTH(DEPTH)) u_array (
    .clk_i   (clk_i),
    .we_i    (we_c),
    .addr_i  (req_d.idx[AW-1:0]),
    .wdata_i (req_q.data),
    .rdata_c (rdata_c)
  );

  // Next state, latency counter and request latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.enable_i) begin
          req_d.write = bus.write_i;
          req_d.idx   = line_index(bus.addr_i);
          req_d.data  = bus.data_i;
          cnt_d       = CNT_W'(LATENCY - 1);
          state_d     = (LATENCY == 1) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Response, write commit and statistics.
  always_comb begin
    in_range_d_c = (req_d.idx < IDX_W'(DEPTH));
    in_range_q_c = (req_q.idx < IDX_W'(DEPTH));
    ack_d        = (state_d == ST_ACK);
    busy_d       = (state_d != ST_IDLE);
    err_d        = ack_d && !in_range_d_c;
    data_d       = data_q;
    we_c         = 1'b0;
    rd_cnt_d     = rd_cnt_q;
    wr_cnt_d     = wr_cnt_q;
    if (ack_d && !req_d.write) begin
      data_d = in_range_d_c ? rdata_c : '0;
    end
    if (state_q == ST_ACK) begin
      if (req_q.write) begin
        we_c = in_range_q_c;
        if (wr_cnt_q != '1) begin
          wr_cnt_d = wr_cnt_q + STAT_W'(1);
        end
      end else begin
        if (rd_cnt_q != '1) begin
          rd_cnt_d = rd_cnt_q + STAT_W'(1);
        end
      end
    end
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      req_q    <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      data_q   <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      data_q   <= data_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign bus.ack_o      = ack_q;
  assign bus.err_o      = err_q;
  assign bus.busy_o     = busy_q;
  assign bus.data_o     = data_q;
  assign bus.rd_count_o = rd_cnt_q;
  assign bus.wr_count_o = wr_cnt_q;

endmodule

// File: doc/line_memory.md
Name: line_memory

Overview:
- Main-memory model that sits directly downstream of the data-cache controller inside the CPU.
- It serves one 256-bit cache line per request over the enable/write/ack handshake.
- Each request completes after a fixed, parameterised access latency.
- It is the target of the cache's write-back and allocate transactions and is instantiated beside CPU in the testbench top.

Parameters:
- LATENCY, 10: cycles from request acceptance to ack; legal range 1..255.
- DEPTH, 512: number of 256-bit lines stored.
- LINE_W, 256: line width in bits; fixed at 256 for this design.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- enable_i  in  1  request valid; the requester holds it, with addr/write/data stable, until ack_o.
- write_i  in  1  1 = write line, 0 = read line; sampled at acceptance.
- addr_i  in  32  byte address; bits [4:0] are ignored; line index = addr_i[31:5].
- data_i  in  LINE_W  write line; sampled at acceptance.
- ack_o  out  1  one-cycle completion pulse.
- data_o  out  LINE_W  read line; valid while ack_o=1 for a read.
- err_o  out  1  pulses with ack_o when line index >= DEPTH.
- busy_o  out  1  high in WAIT and ACK.
- rd_count_o  out  32  completed reads, saturating at 32'hFFFF_FFFF.
- wr_count_o  out  32  completed writes, saturating.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, cnt=0, ack_o=0, err_o=0, data_o=0, counters=0, latched request cleared. Storage array contents are not reset; the testbench preloads them with $readmemb.
- FSM has three states: IDLE, WAIT, ACK.
- IDLE: on a rising edge with enable_i=1, latch addr_i[31:5], write_i and data_i, and set cnt=LATENCY-1.
  - If LATENCY=1, go directly to ACK; otherwise go to WAIT.
  - enable_i=0 keeps the FSM in IDLE.
- WAIT: cnt decrements each edge; when cnt reaches 1, go to ACK.
  - Result: ack_o is high in exactly the LATENCY-th cycle after the acceptance edge.
  - Changes on the inputs during WAIT are ignored; the latched copy is used.
- Entering ACK:
  - Read, in range: data_o <= mem[index].
  - Read, out of range: data_o <= 0 and err_o <= 1.
  - Write: data_o is unchanged.
- ACK cycle:
  - ack_o=1.
  - Write, in range: mem[index] <= latched data at the end of the ACK cycle (the ACK->next edge).
  - Write, out of range: the write is dropped and err_o=1.
  - The matching counter increments at the same edge unless it is saturated.
  - The next state is always IDLE; enable_i during ACK is not accepted.
- Back-to-back requests (e.g. write-back then allocate): the requester drops or updates its request after ack. If enable_i is high in the IDLE cycle after ACK, it is accepted as a new request. The minimum spacing between acks is therefore LATENCY+1 cycles.
- Read-after-write to the same line: because the write commits before the next acceptance, the later read returns the new data.
- data_o holds its last read value outside ACK; consumers must qualify it with ack_o.
- busy_o = (state != IDLE).
- Reset mid-transaction: abort immediately, no write is committed, no ack is issued, and counters return to 0.
- Only one transaction is outstanding at a time; there is no queueing.

Decomposition:
- Shared package line_mem_pkg holds:
  - the state enum {IDLE, WAIT, ACK};
  - LINE_W=256;
  - OFFSET_BITS=5 (log2 of 32 bytes per line);
  - a function line_index(addr) returning addr[31:5].
- One natural sub-module, line_mem_array: a single-port synchronous array of DEPTH x LINE_W, with one write-enable and an asynchronous read port. The FSM, latency counter and statistics stay in line_memory.

Test Plan:
- Preload line 2 with 256'hA5 pattern; read at addr 32'h40 with LATENCY=10 → ack_o pulses exactly 10 cycles after acceptance; data_o = pattern; err_o=0; rd_count_o=1.
- Write 256'h1234 to addr 32'h60, then with enable still high change to a read of 32'h60 in the cycle after ack → second ack arrives 11 cycles after the first; data_o = 256'h1234; wr_count_o=1.
- Read addr 32'h0000_4000 (index 512, DEPTH=512) → ack after LATENCY cycles with err_o=1 and data_o=0; a write to the same address leaves the array unchanged.
- Assert rst_i 4 cycles into a write to 32'h80 → ack_o never pulses; mem[4] is unchanged; state=IDLE; counters=0; a fresh read of 32'h80 returns the old data.
- LATENCY=1 build: enable_i high in IDLE → ack_o in the very next cycle; a continuous enable_i yields one ack every 2 cycles.
- Change addr_i and data_i during WAIT → the completed transaction uses the values latched at acceptance.
